// File: rtl/universal_shift_register.sv
// n-bit universal shift register: hold, shift right, shift left, parallel load.
// Every bit is an identical cell; the generate loop wires each cell to its neighbours or to the serial inputs.

module usr_cell (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] s,
    input  logic       right_in,  // value a right shift moves into this bit
    input  logic       left_in,   // value a left shift moves into this bit
    input  logic       load_in,
    output logic       q
);
    logic nxt;

    always_comb begin
        nxt = q;
        case (s)
            2'b00: nxt = q;
            2'b01: nxt = right_in;
            2'b10: nxt = left_in;
            2'b11: nxt = load_in;
            default: nxt = q;
        endcase
    end

    // Reset overrides the mode mux.
    always_ff @(posedge clk) begin
        if (reset) q <= 1'b0;
        else       q <= nxt;
    end
endmodule

module universal_shift_register #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         MSB_in,
    input  logic         LSB_in,
    input  logic [n-1:0] I,
    input  logic [1:0]   s,
    output logic [n-1:0] Q
);
    logic [n-1:0] right_src;
    logic [n-1:0] left_src;

    for (genvar i = 0; i < n; i++) begin : g_bit
        if (i == n - 1) begin : g_top
            assign right_src[i] = MSB_in;
        end else begin : g_mid_r
            assign right_src[i] = Q[i+1];
        end

        if (i == 0) begin : g_bot
            assign left_src[i] = LSB_in;
        end else begin : g_mid_l
            assign left_src[i] = Q[i-1];
        end

        usr_cell u_cell (
            .clk      (clk),
            .reset    (reset),
            .s        (s),
            .right_in (right_src[i]),
            .left_in  (left_src[i]),
            .load_in  (I[i]),
            .q        (Q[i])
        );
    end
endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench: driver pushes model-predicted Q for widths 4, 8 and 1; a monitor pops after each edge.
module tb_universal_shift_register;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       MSB_in = 1'b0;
    logic       LSB_in = 1'b0;
    logic [1:0] s = 2'b00;
    logic [7:0] din = 8'h00;
    logic [3:0] q4;
    logic [7:0] q8;
    logic       q1;

    typedef struct packed {
        logic [7:0] e4;
        logic [7:0] e8;
        logic [7:0] e1;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         passed = 0;
    logic [7:0] m4 = 8'h00, m8 = 8'h00, m1 = 8'h00;
    bit         done = 1'b0;

    always #5 clk = ~clk;

    universal_shift_register #(.n(4)) dut4 (.clk(clk), .reset(reset), .MSB_in(MSB_in), .LSB_in(LSB_in), .I(din[3:0]), .s(s), .Q(q4));
    universal_shift_register #(.n(8)) dut8 (.clk(clk), .reset(reset), .MSB_in(MSB_in), .LSB_in(LSB_in), .I(din),      .s(s), .Q(q8));
    universal_shift_register #(.n(1)) dut1 (.clk(clk), .reset(reset), .MSB_in(MSB_in), .LSB_in(LSB_in), .I(din[0]),   .s(s), .Q(q1));

    // Register treated as an unsigned number of width w.
    function automatic logic [7:0] model(logic [7:0] r, int w, logic rst, logic [1:0] mode,
                                         logic msb, logic lsb, logic [7:0] d);
        logic [7:0] mask, top;
        mask = 8'hFF >> (8 - w);
        top  = 8'(msb) << (w - 1);
        if (rst) return 8'h00;
        case (mode)
            2'b00:   return r;
            2'b01:   return ((r & mask) >> 1) | top;
            2'b10:   return ((r << 1) | 8'(lsb)) & mask;
            default: return d & mask;
        endcase
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, req, $time);
    endtask

    // Set inputs between edges and queue the state the next edge must produce.
    task automatic step(logic r, logic [1:0] mode, logic msb, logic lsb, logic [7:0] d, bit glitch = 1'b0);
        exp_t e;
        @(negedge clk);
        reset = r; s = mode; MSB_in = msb; LSB_in = lsb; din = d;
        m4 = model(m4, 4, r, mode, msb, lsb, d);
        m8 = model(m8, 8, r, mode, msb, lsb, d);
        m1 = model(m1, 1, r, mode, msb, lsb, d);
        e.e4 = m4; e.e8 = m8; e.e1 = m1;
        sb.push_back(e);
        if (glitch && !r) begin
            // Short reset pulse and a transient mode change, both gone before the edge.
            #1 reset = 1'b1; s = ~mode;
            #2 reset = 1'b0; s = mode;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("q_n4", {4'b0, q4}, e.e4);
            check("q_n8", q8, e.e8);
            check("q_n1", {7'b0, q1}, e.e1);
        end
    end

    initial begin
        // Reset with load selected, then held for a second edge.
        step(1, 2'b11, 0, 0, 8'hFF);
        step(1, 2'b11, 0, 0, 8'hFF);
        // Load 1011, hold three edges while I changes.
        step(0, 2'b11, 0, 0, 8'h0B);
        step(0, 2'b00, 0, 0, 8'h05);
        step(0, 2'b00, 0, 0, 8'h05);
        step(0, 2'b00, 0, 0, 8'h05);
        // Right shifts with MSB_in = 1: 1101, 1110, 1111.
        repeat (3) step(0, 2'b01, 1, 0, 8'h05);
        // Left shifts with LSB_in = 0: 1110, 1100.
        repeat (2) step(0, 2'b10, 0, 0, 8'h00);
        // Load 1110, left with LSB_in = 1: 1101, 1011.
        step(0, 2'b11, 0, 0, 8'h0E);
        repeat (2) step(0, 2'b10, 0, 1, 8'h00);
        // Reset mid-shift, then reload 1110.
        step(0, 2'b11, 0, 0, 8'h0E);
        step(0, 2'b01, 0, 0, 8'h00);
        step(1, 2'b01, 1, 1, 8'hFF);
        step(0, 2'b11, 0, 0, 8'h0E);
        // Width 8: load 10000001, shift left drops the MSB. Width 1 serial fill/drain.
        step(0, 2'b11, 0, 0, 8'h81);
        step(0, 2'b10, 0, 0, 8'h00);
        step(0, 2'b01, 1, 0, 8'h00);
        step(0, 2'b10, 0, 0, 8'h00);
        // Glitch on reset/mode between edges must not disturb state.
        step(0, 2'b11, 0, 0, 8'hA5, 1'b1);
        step(0, 2'b00, 0, 0, 8'h00, 1'b1);
        // Random traffic with occasional resets and glitches.
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 15) == 0), 2'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), ($urandom_range(0, 7) == 0));
        end
        // Drain the scoreboard with a bounded wait.
        begin
            int budget;
            budget = 10;
            while (sb.size() != 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            total++;
            if (sb.size() == 0) passed++;
            else $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parameterised n-bit universal shift register with four synchronous modes: hold, shift right, shift left and parallel load. It is a general-purpose datapath/storage element. It serves serial-to-parallel and parallel-to-serial conversion, bit-stream alignment, and scratch storage inside larger sequential blocks. All state changes occur on the rising clock edge under a single synchronous reset.

## Interface
Parameters:
- n, default 4: register width in bits; legal range n ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock; the only timing reference.
- reset  input  1  synchronous, active-high reset; clears Q on the next rising edge.
- MSB_in  input  1  serial input that enters bit n-1 during a right shift.
- LSB_in  input  1  serial input that enters bit 0 during a left shift.
- I  input  n  parallel load data.
- s  input  2  mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- Q  output  n  register contents, driven directly from the state flops.

## Operation
- State register R[n-1:0] drives Q continuously; there is no combinational path from any input to Q.
- Priority at each rising edge of clk: reset first, then mode s.
- reset = 1: R ← all zeros, regardless of s, I, MSB_in and LSB_in.
- s = 00 (hold): R ← R.
- s = 01 (shift right, toward LSB):
  - R[n-1] ← MSB_in.
  - R[i] ← R[i+1] for i = n-2 down to 0.
  - The old R[0] is discarded.
- s = 10 (shift left, toward MSB):
  - R[0] ← LSB_in.
  - R[i] ← R[i-1] for i = 1 to n-1.
  - The old R[n-1] is discarded.
- s = 11 (parallel load): R ← I.
- All four encodings of s are defined; no illegal modes exist.
- The per-bit next-state logic is a 4:1 mux selected by s. Its inputs are hold, the right neighbour or MSB_in, the left neighbour or LSB_in, and I[i]. The reset override is applied after the mux.
- n = 1 boundary: shift right loads MSB_in and shift left loads LSB_in into the single bit.
- No arithmetic is performed; width is fixed at n and data is never extended or wrapped around. Serial inputs always refill the vacated end; shifted-out bits are lost.

## Timing
- All inputs are sampled only at the rising edge of clk. Q updates in the same edge, so every operation has one-cycle latency.
- Inputs may change at any point between edges; only the value present at the edge matters.
- Reset value: Q = 0 after the first rising edge at which reset = 1. Before that first edge, Q is undefined.
- If reset is asserted mid-sequence (e.g. during shifting), the register clears on that edge and the pending mode is ignored.
- On the first edge after reset deasserts, the register executes the mode on s normally.
- A reset pulse that does not span a rising edge has no effect.
- When s changes between edges, the new mode applies at the next edge only. Consecutive edges in a shift mode shift once per cycle.
- There is no handshake, enable or valid signal; the hold mode (00) is the only stall mechanism.

## Test plan
- Reset: Q = 1011 with reset = 1 at a rising edge and s = 11, I = 1111 → Q = 0000; with reset held for 2 edges → Q stays 0000.
- Load and hold (n = 4): I = 1011, s = 11 for 1 edge → Q = 1011; then s = 00 for 3 edges → Q stays 1011 even while I changes to 0101.
- Shift right: from Q = 1011 with MSB_in = 1, s = 01 → Q goes 1101, then 1110, then 1111 on successive edges.
- Shift left: from Q = 1111 with LSB_in = 0, s = 10 → Q goes 1110, then 1100; from a load of I = 1110 with LSB_in = 1, s = 10 → Q goes 1101, then 1011.
- Reset mid-shift: during right shifting from Q = 1110, assert reset for one edge → Q = 0000; deassert with s = 11, I = 1110 → Q = 1110 on the next edge.
- Width and boundary: with n = 8, load 10000001, then shift left with LSB_in = 0 → Q = 00000010 (MSB lost); with n = 1, s = 01 with MSB_in = 1 → Q = 1, then s = 10 with LSB_in = 0 → Q = 0.
